// File: rtl/nes_bus_pkg.sv
// Shared types and CPU address map for the system bus arbiter.
package nes_bus_pkg;

  localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] PPU_LIMIT = 16'h3FFF;
  localparam logic [15:0] APU_BASE  = 16'h4000;
  localparam logic [15:0] APU_LIMIT = 16'h401F;
  localparam logic [15:0] JPD_BASE  = 16'h4016;
  localparam logic [15:0] JPD_LIMIT = 16'h4017;

  typedef enum logic [2:0] {SLV_RAM, SLV_PPU, SLV_APU, SLV_JPD, SLV_MMC} slv_e;

  typedef enum logic [1:0] {CPU_OWN, HALT, DMA_OWN} arb_state_e;

  // Joypad ports sit inside the APU window, so they are tested first; MMC takes everything above APU.
  function automatic slv_e addr_decode(input logic [15:0] a);
    if (a <= RAM_LIMIT) return SLV_RAM;
    if (a >= PPU_BASE && a <= PPU_LIMIT) return SLV_PPU;
    if (a >= JPD_BASE && a <= JPD_LIMIT) return SLV_JPD;
    if (a >= APU_BASE && a <= APU_LIMIT) return SLV_APU;
    return SLV_MMC;
  endfunction

endpackage

// File: rtl/nes_arb_sel.sv
// Combinational DMA requester pick: lowest pending index, or first pending at/after the pointer.
module nes_arb_sel
  import nes_bus_pkg::*;
#(
  parameter int N     = 2,
  parameter int RR_EN = 1,
  parameter int PW    = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_excl,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_sel,
  output logic          o_valid
);

  logic [N-1:0] w_cand;

  assign w_cand = i_req & ~i_excl;

  always_comb begin
    int j;
    j       = 0;
    o_sel   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (RR_EN != 0) ? ((int'(i_ptr) + i) % N) : i;
      if (!o_valid && w_cand[j]) begin
        o_sel[j] = 1'b1;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nes_bus_arb.sv
// CPU/DMA system bus arbiter with CPU pause, burst limiting and slave read-data return.
//   state   | meaning
//   CPU_OWN | CPU drives the bus, no pause
//   HALT    | pause raised, CPU still drives until it issues a read cycle
//   DMA_OWN | requester r_owner drives the bus, its grant is high
module nes_bus_arb
  import nes_bus_pkg::*;
#(
  parameter int N_DMA     = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int RR_EN     = 1,
  parameter int MAX_BURST = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [ADDR_W-1:0]        i_cpu_addr,
  input  logic                     i_cpu_r_wn,
  input  logic [DATA_W-1:0]        i_cpu_wdata,
  output logic [DATA_W-1:0]        o_cpu_rdata,
  output logic                     o_cpu_pause,
  input  logic [N_DMA-1:0]         i_dma_req,
  output logic [N_DMA-1:0]         o_dma_gnt,
  input  logic [N_DMA*ADDR_W-1:0]  i_dma_addr,
  input  logic [N_DMA-1:0]         i_dma_wn,
  input  logic [N_DMA*DATA_W-1:0]  i_dma_wdata,
  output logic [DATA_W-1:0]        o_dma_rdata,
  output logic [ADDR_W-1:0]        o_bus_addr,
  output logic [DATA_W-1:0]        o_bus_wdata,
  output logic                     o_bus_wn,
  input  logic [DATA_W-1:0]        i_ram_rdata,
  input  logic [DATA_W-1:0]        i_ppu_rdata,
  input  logic [DATA_W-1:0]        i_apu_rdata,
  input  logic [DATA_W-1:0]        i_jpd_rdata,
  input  logic [DATA_W-1:0]        i_mmc_rdata
);

  localparam int PW = (N_DMA > 1) ? $clog2(N_DMA) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e  r_state, w_state_nxt;
  logic [PW-1:0] r_owner, w_owner_nxt;
  logic [PW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic [N_DMA-1:0]  w_own_oh, w_excl, w_sel_oh;
  logic [PW-1:0]     w_ptr_inc, w_sel_ptr, w_sel_idx;
  logic              w_sel_valid, w_req_own, w_burst_tc, w_dma_own;
  logic [ADDR_W-1:0] w_dma_addr;
  logic [DATA_W-1:0] w_dma_wdata, w_rdata;
  logic              w_dma_wn;
  logic [15:0]       w_map_addr;

  always_comb begin
    w_own_oh  = '0;
    w_sel_idx = '0;
    for (int k = 0; k < N_DMA; k++) begin
      w_own_oh[k] = (r_owner == PW'(k));
      if (w_sel_oh[k]) w_sel_idx = PW'(k);
    end
  end

  assign w_ptr_inc  = (int'(r_owner) >= N_DMA - 1) ? '0 : r_owner + 1'b1;
  assign w_dma_own  = (r_state == DMA_OWN);
  assign w_req_own  = |(i_dma_req & w_own_oh);
  assign w_burst_tc = (MAX_BURST != 0) && (r_cnt == CW'(MAX_BURST - 1));
  // While a grant is live, the next pick excludes the owner and searches from just past it.
  assign w_excl     = w_dma_own ? w_own_oh : '0;
  assign w_sel_ptr  = w_dma_own ? w_ptr_inc : r_ptr;

  nes_arb_sel #(.N(N_DMA), .RR_EN(RR_EN), .PW(PW)) u_sel (
    .i_req   (i_dma_req),
    .i_excl  (w_excl),
    .i_ptr   (w_sel_ptr),
    .o_sel   (w_sel_oh),
    .o_valid (w_sel_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = '0;
    case (r_state)
      CPU_OWN: if (|i_dma_req) w_state_nxt = HALT;
      HALT: begin
        if (!(|i_dma_req)) begin
          w_state_nxt = CPU_OWN;
        end else if (i_cpu_r_wn) begin
          w_state_nxt = DMA_OWN;
          w_owner_nxt = w_sel_idx;
        end
      end
      DMA_OWN: begin
        if (!w_req_own) begin
          w_ptr_nxt = w_ptr_inc;
          if (w_sel_valid) w_owner_nxt = w_sel_idx;
          else             w_state_nxt = CPU_OWN;
        end else if (w_burst_tc) begin
          if (w_sel_valid) begin
            w_ptr_nxt   = w_ptr_inc;
            w_owner_nxt = w_sel_idx;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = CPU_OWN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CPU_OWN;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_cpu_pause = (r_state != CPU_OWN);
  assign o_dma_gnt   = w_dma_own ? w_own_oh : '0;

  always_comb begin
    w_dma_addr  = '0;
    w_dma_wdata = '0;
    w_dma_wn    = 1'b1;
    for (int k = 0; k < N_DMA; k++) begin
      if (w_own_oh[k]) begin
        w_dma_addr  = i_dma_addr[k*ADDR_W +: ADDR_W];
        w_dma_wdata = i_dma_wdata[k*DATA_W +: DATA_W];
        w_dma_wn    = i_dma_wn[k];
      end
    end
  end

  // Reset hands the bus straight back to the CPU and blocks any write strobe.
  assign o_bus_addr  = (w_dma_own && !i_rst) ? w_dma_addr  : i_cpu_addr;
  assign o_bus_wdata = (w_dma_own && !i_rst) ? w_dma_wdata : i_cpu_wdata;
  assign o_bus_wn    = i_rst ? 1'b1 : (w_dma_own ? w_dma_wn : i_cpu_r_wn);

  assign w_map_addr = 16'(o_bus_addr);

  always_comb begin
    case (addr_decode(w_map_addr))
      SLV_RAM: w_rdata = i_ram_rdata;
      SLV_PPU: w_rdata = i_ppu_rdata;
      SLV_APU: w_rdata = i_apu_rdata;
      SLV_JPD: w_rdata = i_jpd_rdata;
      default: w_rdata = i_mmc_rdata;
    endcase
  end

  assign o_cpu_rdata = w_rdata;
  assign o_dma_rdata = w_rdata;

endmodule

// File: tb/tb_nes_bus_arb.sv
// Bench for nes_bus_arb: a round-robin/burst-4 instance and a fixed-priority/unlimited instance
// share all inputs; both are compared every cycle against a behavioural bus-ownership model.
module tb_nes_bus_arb;

  localparam int N = 2;
  localparam int M_IDLE = 0, M_WAIT = 1, M_BUS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_rwn;
  logic [7:0]  cpu_wdata;
  logic [1:0]  req;
  logic [31:0] dma_addr;
  logic [1:0]  dma_wn;
  logic [15:0] dma_wdata;
  logic [7:0]  ram_d, ppu_d, apu_d, jpd_d, mmc_d;

  logic [7:0]  a_cpu_rdata, a_dma_rdata, a_bus_wdata, b_cpu_rdata, b_dma_rdata, b_bus_wdata;
  logic        a_pause, a_bus_wn, b_pause, b_bus_wn;
  logic [1:0]  a_gnt, b_gnt;
  logic [15:0] a_bus_addr, b_bus_addr;

  int n_checks = 0;
  int n_err    = 0;

  int m_mode [2];
  int m_owner[2];
  int m_cnt  [2];
  int m_ptr  [2];
  int rr_cfg [2] = '{1, 0};
  int mb_cfg [2] = '{4, 0};

  nes_bus_arb #(.N_DMA(2), .ADDR_W(16), .DATA_W(8), .RR_EN(1), .MAX_BURST(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_cpu_addr(cpu_addr), .i_cpu_r_wn(cpu_rwn),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(a_cpu_rdata), .o_cpu_pause(a_pause),
    .i_dma_req(req), .o_dma_gnt(a_gnt), .i_dma_addr(dma_addr), .i_dma_wn(dma_wn),
    .i_dma_wdata(dma_wdata), .o_dma_rdata(a_dma_rdata), .o_bus_addr(a_bus_addr),
    .o_bus_wdata(a_bus_wdata), .o_bus_wn(a_bus_wn), .i_ram_rdata(ram_d),
    .i_ppu_rdata(ppu_d), .i_apu_rdata(apu_d), .i_jpd_rdata(jpd_d), .i_mmc_rdata(mmc_d)
  );

  nes_bus_arb #(.N_DMA(2), .ADDR_W(16), .DATA_W(8), .RR_EN(0), .MAX_BURST(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_cpu_addr(cpu_addr), .i_cpu_r_wn(cpu_rwn),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(b_cpu_rdata), .o_cpu_pause(b_pause),
    .i_dma_req(req), .o_dma_gnt(b_gnt), .i_dma_addr(dma_addr), .i_dma_wn(dma_wn),
    .i_dma_wdata(dma_wdata), .o_dma_rdata(b_dma_rdata), .o_bus_addr(b_bus_addr),
    .o_bus_wdata(b_bus_wdata), .o_bus_wn(b_bus_wn), .i_ram_rdata(ram_d),
    .i_ppu_rdata(ppu_d), .i_apu_rdata(apu_d), .i_jpd_rdata(jpd_d), .i_mmc_rdata(mmc_d)
  );

  function automatic logic [7:0] exp_rdata(input logic [15:0] a);
    if (a < 16'h2000) return ram_d;
    if (a < 16'h4000) return ppu_d;
    if (a == 16'h4016 || a == 16'h4017) return jpd_d;
    if (a < 16'h4020) return apu_d;
    return mmc_d;
  endfunction

  function automatic int pick(input logic [1:0] r, input int start, input int excl, input int rr);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (rr != 0) ? (start + i) % N : i;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_mode[d] = M_IDLE; m_owner[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0;
      end else if (m_mode[d] == M_IDLE) begin
        if (req != 2'b00) m_mode[d] = M_WAIT;
      end else if (m_mode[d] == M_WAIT) begin
        if (req == 2'b00) m_mode[d] = M_IDLE;
        else if (cpu_rwn) begin
          m_owner[d] = pick(req, m_ptr[d], -1, rr_cfg[d]);
          m_mode[d]  = M_BUS;
          m_cnt[d]   = 0;
        end
      end else begin
        int k, nxt;
        k   = m_owner[d];
        nxt = pick(req, (k + 1) % N, k, rr_cfg[d]);
        if (!req[k]) begin
          m_ptr[d] = (k + 1) % N;
          m_cnt[d] = 0;
          if (nxt >= 0) m_owner[d] = nxt;
          else begin m_mode[d] = M_IDLE; m_owner[d] = -1; end
        end else if (mb_cfg[d] != 0 && m_cnt[d] == mb_cfg[d] - 1) begin
          m_cnt[d] = 0;
          if (nxt >= 0) begin m_ptr[d] = (k + 1) % N; m_owner[d] = nxt; end
        end else begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
  endtask

  task automatic check(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL dut%0d %s: observed %0h expected %0h", d, tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [1:0] gnt, input logic pause,
                           input logic [15:0] baddr, input logic bwn, input logic [7:0] bwd,
                           input logic [7:0] drd, input logic [7:0] crd);
    logic [15:0] ea; logic ewn; logic [7:0] ewd; logic [1:0] eg; logic ep;
    ep = (m_mode[d] != M_IDLE);
    eg = (m_mode[d] == M_BUS) ? (2'b01 << m_owner[d]) : 2'b00;
    if (!rst && m_mode[d] == M_BUS) begin
      ea  = dma_addr[m_owner[d]*16 +: 16];
      ewn = dma_wn[m_owner[d]];
      ewd = dma_wdata[m_owner[d]*8 +: 8];
    end else begin
      ea  = cpu_addr;
      ewn = rst ? 1'b1 : cpu_rwn;
      ewd = cpu_wdata;
    end
    check(d, "gnt", 32'(gnt), 32'(eg));
    check(d, "pause", 32'(pause), 32'(ep));
    check(d, "bus_addr", 32'(baddr), 32'(ea));
    check(d, "bus_wn", 32'(bwn), 32'(ewn));
    check(d, "bus_wdata", 32'(bwd), 32'(ewd));
    check(d, "dma_rdata", 32'(drd), 32'(exp_rdata(ea)));
    if (!ep) check(d, "cpu_rdata", 32'(crd), 32'(exp_rdata(ea)));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_dut(0, a_gnt, a_pause, a_bus_addr, a_bus_wn, a_bus_wdata, a_dma_rdata, a_cpu_rdata);
    check_dut(1, b_gnt, b_pause, b_bus_addr, b_bus_wn, b_bus_wdata, b_dma_rdata, b_cpu_rdata);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 16'($urandom_range(0, 16'h1FFF));
      1: return 16'($urandom_range(16'h2000, 16'h3FFF));
      2: return 16'($urandom_range(16'h4000, 16'h401F));
      3: return 16'($urandom_range(16'h4016, 16'h4017));
      4: return 16'($urandom_range(16'h4020, 16'hFFFF));
      default: begin
        logic [15:0] edges [8];
        edges = '{16'h1FFF, 16'h2000, 16'h3FFF, 16'h4000, 16'h4015, 16'h4018, 16'h401F, 16'h4020};
        return edges[$urandom_range(0, 7)];
      end
    endcase
  endfunction

  initial begin
    rst = 1'b1; cpu_addr = 16'h0000; cpu_rwn = 1'b1; cpu_wdata = 8'h00;
    req = 2'b00; dma_addr = {16'hC123, 16'h0300}; dma_wn = 2'b11; dma_wdata = 16'hB2A1;
    ram_d = 8'h5A; ppu_d = 8'h22; apu_d = 8'h33; jpd_d = 8'h44; mmc_d = 8'h55;

    // Reset, then CPU idle read from RAM
    cycle(); cycle();
    rst = 1'b0; cpu_addr = 16'h0005;
    cycle();
    check(0, "idle_rdata", 32'(a_cpu_rdata), 32'h5A);
    check(0, "idle_addr", 32'(a_bus_addr), 32'h0005);
    check(0, "idle_pause", 32'(a_pause), 32'h0);
    check(0, "idle_gnt", 32'(a_gnt), 32'h0);

    // Single DMA on requester 1 with the CPU reading
    req = 2'b10;
    cycle();
    check(0, "dma1_pause_t1", 32'(a_pause), 32'h1);
    check(0, "dma1_gnt_t1", 32'(a_gnt), 32'h0);
    cycle();
    check(0, "dma1_gnt_t2", 32'(a_gnt), 32'h2);
    check(0, "dma1_addr_t2", 32'(a_bus_addr), 32'hC123);
    repeat (3) cycle();
    req = 2'b00;
    cycle();
    check(0, "dma1_gnt_end", 32'(a_gnt), 32'h0);
    check(0, "dma1_pause_end", 32'(a_pause), 32'h0);

    // CPU writes in flight when requester 0 asks; grant waits for the first read
    cpu_rwn = 1'b0; req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 16'h0100 + 16'(i); cpu_wdata = 8'hA0 + 8'(i);
      cycle();
      check(0, "wr_addr", 32'(a_bus_addr), 32'h0100 + i);
      check(0, "wr_wn", 32'(a_bus_wn), 32'h0);
      check(0, "wr_gnt", 32'(a_gnt), 32'h0);
    end
    cpu_rwn = 1'b1; cpu_addr = 16'h0200;
    cycle();
    check(0, "wr_gnt_after_read", 32'(a_gnt), 32'h1);
    check(1, "wr_gnt_after_read", 32'(b_gnt), 32'h1);
    repeat (6) cycle();
    req = 2'b00;
    cycle(); cycle();

    // Round-robin rotation every 4 cycles vs fixed priority holding index 0
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    req = 2'b11;
    cycle(); cycle();
    for (int i = 0; i < 12; i++) begin
      check(0, "rr_gnt", 32'(a_gnt), ((i / 4) % 2 == 0) ? 32'h1 : 32'h2);
      check(0, "rr_pause", 32'(a_pause), 32'h1);
      check(1, "fixed_gnt", 32'(b_gnt), 32'h1);
      cycle();
    end

    // Fixed priority hand-off when requester 0 drops
    req = 2'b10;
    cycle();
    check(1, "handoff_gnt", 32'(b_gnt), 32'h2);
    check(1, "handoff_pause", 32'(b_pause), 32'h1);
    check(0, "handoff_gnt", 32'(a_gnt), 32'h2);

    // Reset in the middle of a DMA grant
    rst = 1'b1; cpu_rwn = 1'b0; dma_wn = 2'b00; cpu_addr = 16'h0777;
    cycle();
    check(0, "rst_gnt", 32'(a_gnt), 32'h0);
    check(0, "rst_pause", 32'(a_pause), 32'h0);
    check(0, "rst_wn", 32'(a_bus_wn), 32'h1);
    check(0, "rst_addr", 32'(a_bus_addr), 32'h0777);
    rst = 1'b0; cpu_rwn = 1'b1; req = 2'b00;
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      rst       = ($urandom_range(0, 99) == 0);
      cpu_rwn   = ($urandom_range(0, 3) != 0);
      cpu_addr  = rand_addr();
      cpu_wdata = 8'($urandom);
      dma_addr  = {rand_addr(), rand_addr()};
      dma_wn    = 2'($urandom);
      dma_wdata = 16'($urandom);
      ram_d = 8'($urandom); ppu_d = 8'($urandom); apu_d = 8'($urandom);
      jpd_d = 8'($urandom); mmc_d = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
